alu_result_packer: RTL and testbench
====================================

# alu_result_packer

Downstream capture stage for the dual 8-bit ALU/XOR macro. Each cycle that a result is flagged valid, it latches the full result bundle (two ALU outputs, two carries, XOR byte `x`, parity bit `y`) into a small FIFO. It then streams each record out as four bytes over an 8-bit valid/ready port. This decouples the ALU's per-cycle results from a slower byte-wide consumer such as GPIO pads or a Wishbone-readable mailbox.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries; must be a power of 2, minimum 2.
- `AW`, default `$clog2(DEPTH)`: FIFO pointer width.

Ports:
- `wb_clk_i`, input, 1: single clock.
- `wb_rst_i`, input, 1: reset; synchronous, active-high.
- `cap_valid_i`, input, 1: the ALU result bundle is valid this cycle.
- `alu_out1_i`, input, 8: ALU_Out1.
- `alu_out2_i`, input, 8: ALU_Out2.
- `carry1_i`, input, 1: CarryOut1.
- `carry2_i`, input, 1: CarryOut2.
- `x_i`, input, 8: XOR result byte.
- `y_i`, input, 1: single-bit XOR/parity result.
- `cap_ready_o`, output, 1: FIFO not full; this is a registered view of start-of-cycle state.
- `ser_data_o`, output, 8: current output byte.
- `ser_valid_o`, output, 1: `ser_data_o` is valid.
- `ser_ready_i`, input, 1: the consumer accepts the byte.
- `ser_last_o`, output, 1: the current byte is byte 3 of a record.
- `count_o`, output, AW+1: FIFO occupancy (0..DEPTH). Excludes the record held in the serializer.
- `overflow_o`, output, 1: sticky flag; a capture was dropped.

## Operation

- Record packing, 27 bits, sent as 4 bytes in this order:
  - byte0 = `alu_out1_i`
  - byte1 = `alu_out2_i`
  - byte2 = `x_i`
  - byte3 = `{5'b0, y_i, carry2_i, carry1_i}`
- Push: when `cap_valid_i` is high and `count_o` is less than DEPTH at the start of the cycle, write to `mem[wptr]` and increment `wptr`. Pointers are AW bits and wrap modulo DEPTH.
- Full push: when `cap_valid_i` is high and the FIFO is full at the start of the cycle, the record is dropped and `overflow_o` is set to 1.
  - This holds even if a pop occurs in the same cycle. No same-cycle bypass.
  - `overflow_o` clears only on `wb_rst_i`.
- Serializer FSM with two states:
  - **IDLE**:
    - `ser_valid_o` = 0.
    - If the FIFO is non-empty: pop `mem[rptr]` into the 32-bit holding register, set byte index to 0, and go to SEND.
  - **SEND**:
    - `ser_valid_o` = 1, `ser_data_o` = holding byte[idx], `ser_last_o` = (idx == 3).
    - On `ser_valid_o && ser_ready_i` with idx < 3: idx increments.
    - On the handshake with idx == 3: if the FIFO is non-empty, pop the next record, set idx to 0 and stay in SEND (back-to-back, no bubble). Otherwise go to IDLE.
    - While `ser_ready_i` is low, `ser_data_o`, `ser_valid_o` and `ser_last_o` hold stable.
- Simultaneous push and pop: both take effect and `count_o` is unchanged.
- Push into an empty FIFO: the record is not bypassed. The pop occurs on the following cycle.

## Timing

- Reset values:
  - state = IDLE
  - `wptr`, `rptr`, `count_o`, idx = 0
  - `ser_valid_o`, `ser_last_o`, `overflow_o` = 0
  - `ser_data_o` = 8'h00
  - `cap_ready_o` = 1
  - FIFO memory is not reset.
- Reset mid-record: the partial record and all queued records are discarded. `ser_valid_o` is 0 from the cycle after the reset edge.
- Latency: a capture at edge N, with an empty FIFO and serializer in IDLE, reaches the FIFO at N, pops at N+1, and presents `ser_valid_o` with byte0 after edge N+1 (2 cycles).
- Throughput: 1 byte per cycle with `ser_ready_i` held high, i.e. one record per 4 cycles. Sustained capture faster than that overflows after DEPTH+1 records.
- `cap_ready_o` and `count_o` are registered and reflect state after the last edge.

## Structure

- Shared package `alu_pkg`:
  - `localparam REC_BYTES = 4`
  - a typedef for the packed 32-bit record
  - state enum {IDLE, SEND}
- One sub-module is natural: `sync_fifo` (parameterized width and depth, synchronous reset on pointers and count, `full`/`empty` outputs). The serializer FSM lives in the top module.

## Test plan

- Single capture: after reset, capture {out1=8'hA5, out2=8'h3C, c1=1, c2=0, x=8'h99, y=1} with `ser_ready_i`=1. Required: valid bytes A5, 3C, 99, 05 on 4 consecutive cycles starting 2 cycles after capture; `ser_last_o` high only on 05.
- Back-pressure: hold `ser_ready_i`=0 for 5 cycles mid-record. Required: `ser_data_o` and `ser_last_o` stable throughout; no byte lost or repeated.
- Fill and overflow (DEPTH=4): with `ser_ready_i`=0, capture 6 records on consecutive cycles.
  - Required: the first record goes to the serializer and 4 fill the FIFO (`count_o`=4, `cap_ready_o`=0). The 6th is dropped and `overflow_o`=1.
  - Draining yields records 1–5 in order.
- Back-to-back: queue 3 records, then hold ready=1. Required: 12 contiguous valid bytes with no idle cycle between records, then `ser_valid_o`=0.
- Simultaneous push/pop at full: push on the same cycle as a pop with FIFO full. Required: the push is dropped, `overflow_o`=1, and `count_o` decrements to 3.
- Reset mid-operation: assert `wb_rst_i` during byte1 with 2 records queued. Required: all outputs at their reset values next cycle, `count_o`=0, and no stale bytes emitted afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU result capture path.
//   REC_BYTES   - bytes per serialized result record
//   rec_t       - packed record, byte0 in the low byte
//   state_t     - serializer FSM states
//   pack_record - builds a record from the raw ALU result bundle
package alu_pkg;

  localparam int REC_BYTES = 4;
  localparam int IDX_W     = $clog2(REC_BYTES);

  // Indexable by byte number: rec[0] is the first byte on the wire.
  typedef logic [REC_BYTES-1:0][7:0] rec_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // byte0 = out1, byte1 = out2, byte2 = x, byte3 = {5'b0, y, c2, c1}
  function automatic rec_t pack_record(
    input logic [7:0] out1,
    input logic [7:0] out2,
    input logic [7:0] x,
    input logic       c1,
    input logic       c2,
    input logic       y
  );
    rec_t r;
    r[0] = out1;
    r[1] = out2;
    r[2] = x;
    r[3] = {5'b00000, y, c2, c1};
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy.
//   i_clk, i_rst  - clock and synchronous active-high reset (pointers/count)
//   i_push/i_wdata - write request; ignored when full at start of cycle
//   i_pop/o_rdata  - read request; o_rdata shows the head entry
//   o_full/o_empty - derived from the registered count
//   o_count        - occupancy 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Full/empty judged on start-of-cycle count: a pop never frees room for a same-cycle push.
  assign o_full    = (r_count == CNT_DEPTH);
  assign o_empty   = (r_count == {(AW+1){1'b0}});
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr];
  assign o_count   = r_count;

  // Pointer and occupancy registers; pointers wrap modulo DEPTH
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/alu_result_packer.sv
// alu_result_packer: captures ALU result bundles into a FIFO and streams
// each record out as four bytes over a valid/ready port.
//   wb_clk_i, wb_rst_i       - clock, synchronous active-high reset
//   cap_valid_i + bundle     - alu_out1_i, alu_out2_i, carry1_i, carry2_i, x_i, y_i
//   cap_ready_o              - FIFO not full (registered state)
//   ser_data_o/valid/last    - byte stream out; last marks byte3
//   ser_ready_i              - consumer accepts the current byte
//   count_o                  - FIFO occupancy, excluding the record being sent
//   overflow_o               - sticky: a capture was dropped
module alu_result_packer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cap_valid_i,
  input  logic [7:0]    alu_out1_i,
  input  logic [7:0]    alu_out2_i,
  input  logic          carry1_i,
  input  logic          carry2_i,
  input  logic [7:0]    x_i,
  input  logic          y_i,
  output logic          cap_ready_o,
  output logic [7:0]    ser_data_o,
  output logic          ser_valid_o,
  input  logic          ser_ready_i,
  output logic          ser_last_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REC_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  rec_t             w_rec;
  rec_t             w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_pop;
  state_t           r_state;
  state_t           w_state_nxt;
  rec_t             r_hold;
  logic [IDX_W-1:0] r_idx;
  logic             r_overflow;

  assign w_rec       = pack_record(alu_out1_i, alu_out2_i, x_i, carry1_i, carry2_i, y_i);
  assign cap_ready_o = !w_fifo_full;
  assign overflow_o  = r_overflow;

  sync_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (cap_valid_i),
    .i_wdata (w_rec),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (count_o)
  );

  // Sticky overflow: a capture arriving while full is lost, even if a pop happens too
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_overflow <= 1'b0;
    end else if (cap_valid_i && w_fifo_full) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Serializer state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and pop decision; popping on the final handshake avoids a bubble
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SEND: begin
        if (ser_ready_i && (r_idx == IDX_LAST)) begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = SEND;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = SEND;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Holding register and byte index
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_hold <= '0;
      r_idx  <= {IDX_W{1'b0}};
    end else if (w_pop) begin
      r_hold <= w_fifo_rdata;
      r_idx  <= {IDX_W{1'b0}};
    end else if ((r_state == SEND) && ser_ready_i) begin
      r_idx  <= r_idx + IDX_ONE;
    end else begin
      r_idx  <= r_idx;
    end
  end

  // Moore outputs: only registered state feeds the byte port, so it holds under back-pressure
  always_comb begin
    ser_valid_o = 1'b0;
    ser_data_o  = 8'h00;
    ser_last_o  = 1'b0;
    case (r_state)
      SEND: begin
        ser_valid_o = 1'b1;
        ser_data_o  = r_hold[r_idx];
        ser_last_o  = (r_idx == IDX_LAST);
      end
      IDLE: begin
        ser_valid_o = 1'b0;
      end
      default: begin
        ser_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_result_packer.sv
// tb_alu_result_packer: directed-vector bench for alu_result_packer (DEPTH=4).
module tb_alu_result_packer;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       cap_valid_i;
  logic [7:0] alu_out1_i;
  logic [7:0] alu_out2_i;
  logic       carry1_i;
  logic       carry2_i;
  logic [7:0] x_i;
  logic       y_i;
  logic       cap_ready_o;
  logic [7:0] ser_data_o;
  logic       ser_valid_o;
  logic       ser_ready_i;
  logic       ser_last_o;
  logic [2:0] count_o;
  logic       overflow_o;

  int n_vec = 0;
  int n_err = 0;

  alu_result_packer #(.DEPTH(4)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cap_valid_i (cap_valid_i),
    .alu_out1_i  (alu_out1_i),
    .alu_out2_i  (alu_out2_i),
    .carry1_i    (carry1_i),
    .carry2_i    (carry2_i),
    .x_i         (x_i),
    .y_i         (y_i),
    .cap_ready_o (cap_ready_o),
    .ser_data_o  (ser_data_o),
    .ser_valid_o (ser_valid_o),
    .ser_ready_i (ser_ready_i),
    .ser_last_o  (ser_last_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Test record k: out1=10+k, out2=20+k, x=30+k, c1=k[0], c2=k[1], y=k[2]
  function automatic logic [7:0] rec_byte(input int k, input int b);
    logic [7:0] kk;
    kk = k[7:0];
    case (b)
      0:       rec_byte = 8'h10 + kk;
      1:       rec_byte = 8'h20 + kk;
      2:       rec_byte = 8'h30 + kk;
      default: rec_byte = {5'b00000, kk[2], kk[1], kk[0]};
    endcase
  endfunction

  task automatic set_rec(input int k);
    logic [7:0] kk;
    kk          = k[7:0];
    cap_valid_i = 1'b1;
    alu_out1_i  = 8'h10 + kk;
    alu_out2_i  = 8'h20 + kk;
    x_i         = 8'h30 + kk;
    carry1_i    = kk[0];
    carry2_i    = kk[1];
    y_i         = kk[2];
  endtask

  // Expects records first..first+n-1 on consecutive cycles with ready held high
  task automatic drain(input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      for (int b = 0; b < 4; b++) begin
        check_val($sformatf("drain_valid r%0d b%0d", k, b), {31'd0, ser_valid_o}, 32'd1);
        check_val($sformatf("drain_data r%0d b%0d", k, b), {24'd0, ser_data_o}, {24'd0, rec_byte(k, b)});
        check_val($sformatf("drain_last r%0d b%0d", k, b), {31'd0, ser_last_o}, (b == 3) ? 32'd1 : 32'd0);
        tick();
      end
    end
    check_val("drain_idle_after", {31'd0, ser_valid_o}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_valid"},    {31'd0, ser_valid_o}, 32'd0);
    check_val({tag, "_last"},     {31'd0, ser_last_o},  32'd0);
    check_val({tag, "_data"},     {24'd0, ser_data_o},  32'h00);
    check_val({tag, "_count"},    {29'd0, count_o},     32'd0);
    check_val({tag, "_overflow"}, {31'd0, overflow_o},  32'd0);
    check_val({tag, "_capready"}, {31'd0, cap_ready_o}, 32'd1);
  endtask

  logic [7:0] single_exp [4];

  initial begin
    wb_rst_i    = 1'b1;
    cap_valid_i = 1'b0;
    alu_out1_i  = 8'h00;
    alu_out2_i  = 8'h00;
    carry1_i    = 1'b0;
    carry2_i    = 1'b0;
    x_i         = 8'h00;
    y_i         = 1'b0;
    ser_ready_i = 1'b0;
    tick();
    tick();
    wb_rst_i = 1'b0;
    check_reset_vals("reset");

    // Single capture, 2-cycle latency, bytes A5 3C 99 05
    single_exp[0] = 8'hA5;
    single_exp[1] = 8'h3C;
    single_exp[2] = 8'h99;
    single_exp[3] = 8'h05;
    ser_ready_i = 1'b1;
    cap_valid_i = 1'b1;
    alu_out1_i  = 8'hA5;
    alu_out2_i  = 8'h3C;
    carry1_i    = 1'b1;
    carry2_i    = 1'b0;
    x_i         = 8'h99;
    y_i         = 1'b1;
    tick();
    cap_valid_i = 1'b0;
    check_val("single_count_after_cap", {29'd0, count_o}, 32'd1);
    check_val("single_not_yet_valid", {31'd0, ser_valid_o}, 32'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      check_val($sformatf("single_valid b%0d", b), {31'd0, ser_valid_o}, 32'd1);
      check_val($sformatf("single_data b%0d", b), {24'd0, ser_data_o}, {24'd0, single_exp[b]});
      check_val($sformatf("single_last b%0d", b), {31'd0, ser_last_o}, (b == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check_val("single_idle_after", {31'd0, ser_valid_o}, 32'd0);

    // Back-pressure for 5 cycles while byte1 of record 2 is presented
    set_rec(2);
    tick();
    cap_valid_i = 1'b0;
    tick();
    check_val("bp_b0", {24'd0, ser_data_o}, {24'd0, rec_byte(2, 0)});
    tick();
    ser_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("bp_hold_valid %0d", i), {31'd0, ser_valid_o}, 32'd1);
      check_val($sformatf("bp_hold_data %0d", i), {24'd0, ser_data_o}, {24'd0, rec_byte(2, 1)});
      check_val($sformatf("bp_hold_last %0d", i), {31'd0, ser_last_o}, 32'd0);
      tick();
    end
    ser_ready_i = 1'b1;
    check_val("bp_b1_release", {24'd0, ser_data_o}, {24'd0, rec_byte(2, 1)});
    tick();
    check_val("bp_b2", {24'd0, ser_data_o}, {24'd0, rec_byte(2, 2)});
    tick();
    check_val("bp_b3", {24'd0, ser_data_o}, {24'd0, rec_byte(2, 3)});
    check_val("bp_b3_last", {31'd0, ser_last_o}, 32'd1);
    tick();
    check_val("bp_idle_after", {31'd0, ser_valid_o}, 32'd0);

    // Fill and overflow: six captures on consecutive cycles, consumer stalled
    ser_ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_rec(k);
      tick();
    end
    check_val("fill_count4", {29'd0, count_o}, 32'd4);
    check_val("fill_capready0", {31'd0, cap_ready_o}, 32'd0);
    check_val("fill_no_overflow_yet", {31'd0, overflow_o}, 32'd0);
    set_rec(6);
    tick();
    cap_valid_i = 1'b0;
    check_val("ovf_count4", {29'd0, count_o}, 32'd4);
    check_val("ovf_flag", {31'd0, overflow_o}, 32'd1);
    ser_ready_i = 1'b1;
    drain(1, 5);
    check_val("ovf_drained_count", {29'd0, count_o}, 32'd0);
    check_val("ovf_sticky", {31'd0, overflow_o}, 32'd1);

    // Back-to-back: three queued records give 12 contiguous bytes
    ser_ready_i = 1'b0;
    for (int k = 7; k <= 9; k++) begin
      set_rec(k);
      tick();
    end
    cap_valid_i = 1'b0;
    check_val("b2b_count2", {29'd0, count_o}, 32'd2);
    ser_ready_i = 1'b1;
    drain(7, 3);

    // Push coinciding with a pop while full: push dropped, count 4 -> 3
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    ser_ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_rec(k);
      tick();
    end
    cap_valid_i = 1'b0;
    check_val("pp_full_count", {29'd0, count_o}, 32'd4);
    check_val("pp_overflow_clear", {31'd0, overflow_o}, 32'd0);
    ser_ready_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      check_val($sformatf("pp_r1 b%0d", b), {24'd0, ser_data_o}, {24'd0, rec_byte(1, b)});
      tick();
    end
    check_val("pp_r1_b3", {24'd0, ser_data_o}, {24'd0, rec_byte(1, 3)});
    set_rec(6);
    tick();
    cap_valid_i = 1'b0;
    check_val("pp_overflow_set", {31'd0, overflow_o}, 32'd1);
    check_val("pp_count3", {29'd0, count_o}, 32'd3);
    check_val("pp_capready1", {31'd0, cap_ready_o}, 32'd1);
    drain(2, 4);

    // Reset during byte1 with two records queued
    ser_ready_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      set_rec(k);
      tick();
    end
    cap_valid_i = 1'b0;
    check_val("rst_mid_count2", {29'd0, count_o}, 32'd2);
    ser_ready_i = 1'b1;
    tick();
    check_val("rst_mid_b1", {24'd0, ser_data_o}, {24'd0, rec_byte(1, 1)});
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    check_reset_vals("rst_mid");
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val($sformatf("rst_no_stale_valid %0d", i), {31'd0, ser_valid_o}, 32'd0);
      check_val($sformatf("rst_no_stale_count %0d", i), {29'd0, count_o}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
